// File: rtl/ram_rd_sequencer.sv
// rtl/ram_rd_sequencer.sv - streams a run of consecutive RAM words onto a valid/ready stream
// A 2-entry buffer absorbs the RAM's one-cycle read latency so backpressure never drops a word.
module ram_rd_sequencer #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_rden,
    output logic [AWIDTH-1:0] ram_rdaddr,
    input  logic [DWIDTH-1:0] ram_do,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic              inflight_q;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] tail_q, tail_d;
    logic              done_q, done_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;

    assign dout_valid = (fifo_cnt_q != 2'd0);
    assign dout       = head_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign ram_rden   = issue;
    assign ram_rdaddr = addr_q;

    assign pop       = dout_valid & dout_ready;
    assign push      = inflight_q;
    // Buffered words plus the read still in the RAM pipeline; a same-cycle pop frees one slot.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign issue     = (state_q == S_RUN) && !abort && (issue_cnt_q != '0)
                       && (occupancy < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        fifo_cnt_d  = fifo_cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        done_d      = 1'b0;

        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    head_d = ram_do;
                end else begin
                    tail_d = ram_do;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d     = tail_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    head_d = ram_do;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_do;
                end
            end
            default: ;
        endcase

        if (issue) begin
            addr_d      = addr_q + 1'b1;
            issue_cnt_d = issue_cnt_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = S_RUN;
                        addr_d      = base_addr;
                        issue_cnt_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue && (issue_cnt_q == 1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (fifo_cnt_q == 2'd1) && !inflight_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards buffered words and any read already in the RAM pipeline.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            fifo_cnt_d  = 2'd0;
            issue_cnt_d = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            inflight_q  <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= issue;
            fifo_cnt_q  <= fifo_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ram_rd_sequencer.sv
// tb/tb_ram_rd_sequencer.sv - randomized bench with a counting reference model for ram_rd_sequencer
module tb_ram_rd_sequencer;
    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dout_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, ram_rden, dout_valid;
    logic [AW-1:0] ram_rdaddr;
    logic [DW-1:0] ram_do = '0;
    logic [DW-1:0] dout;

    always #5 clk = ~clk;

    ram_rd_sequencer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .abort(abort), .busy(busy), .done(done), .ram_rden(ram_rden),
        .ram_rdaddr(ram_rdaddr), .ram_do(ram_do), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_rden) ram_do <= mem[ram_rdaddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a run is described only by counts of reads issued and beats delivered.
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0, m_done = 1'b0, m_rst = 1'b0, m_hold = 1'b0, m_prev_rden = 1'b0;
    int            m_base = 0, m_len = 0, m_issued = 0, m_beats = 0;
    logic [DW-1:0] m_hold_data = '0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] beat_log [$];
    int            beat_cyc [$];
    int            addr_log [$];
    int            done_cyc = -1;
    int            done_cnt = 0;
    bit            c_pop;
    int            c_outst;

    always @(negedge clk) begin
        c_pop = dout_valid && dout_ready;
        if (chk_en) begin
            if (m_rst) begin
                chk("rst_rdaddr", ram_rdaddr, 0);
                chk("rst_dout", dout, 0);
            end
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) begin
                chk("idle_rden", ram_rden, 0);
                chk("idle_valid", dout_valid, 0);
            end else begin
                c_outst = m_issued - m_beats - int'(m_prev_rden);
                chk("valid", dout_valid, c_outst > 0);
                if (!abort && !reset)
                    chk("rden", ram_rden,
                        (m_issued < m_len) && ((m_issued - m_beats - int'(c_pop)) < 2));
                if (ram_rden) chk("rdaddr", ram_rdaddr, (m_base + m_issued) % DEPTH);
            end
            if (m_hold) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_data", dout, m_hold_data);
            end
            if (c_pop) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat_data", dout, exp_q[0]);
            end
        end
        if (ram_rden) addr_log.push_back(int'(ram_rdaddr));
        if (c_pop) begin
            beat_log.push_back(dout);
            beat_cyc.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end

        m_done      = 1'b0;
        m_hold      = dout_valid && !dout_ready && !abort && !reset;
        m_hold_data = dout;
        if (reset) begin
            m_busy      = 1'b0;
            m_rst       = 1'b1;
            m_prev_rden = 1'b0;
            exp_q.delete();
        end else begin
            m_rst = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    if (len == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_busy      = 1'b1;
                        m_base      = int'(base_addr);
                        m_len       = int'(len);
                        m_issued    = 0;
                        m_beats     = 0;
                        m_prev_rden = 1'b0;
                        exp_q.delete();
                        for (int i = 0; i < m_len; i++) exp_q.push_back(mem[(m_base + i) % DEPTH]);
                    end
                end
            end else if (abort) begin
                m_busy = 1'b0;
                exp_q.delete();
            end else begin
                if (ram_rden) m_issued++;
                m_prev_rden = ram_rden;
                if (c_pop) begin
                    m_beats++;
                    if (m_beats == m_len) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // 0: ready high, 1: random with 5-cycle low stretches, 2: ready low, 3: driven by main sequence
    int rmode = 0;
    initial begin
        int stretch;
        stretch = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: dout_ready = 1'b1;
                1: begin
                    if (stretch > 0) begin
                        dout_ready = 1'b0;
                        stretch--;
                    end else if ($urandom_range(0, 7) == 0) begin
                        dout_ready = 1'b0;
                        stretch = 4;
                    end else begin
                        dout_ready = 1'($urandom_range(0, 1));
                    end
                end
                2: dout_ready = 1'b0;
                default: ;
            endcase
        end
    end

    task automatic clr();
        beat_log.delete();
        beat_cyc.delete();
        addr_log.delete();
    endtask

    task automatic do_start(input int b, input int l, output int t);
        base_addr = b[AW-1:0];
        len       = l[AW:0];
        start     = 1'b1;
        t         = cyc;
        step(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1);
            n++;
        end
        chk("done_timeout", done_cnt > d0, 1);
    endtask

    task automatic wait_beats(input int want, input int budget);
        int n;
        n = 0;
        while (beat_log.size() < want && n < budget) begin
            step(1);
            n++;
        end
        chk("beats_timeout", beat_log.size() >= want, 1);
    endtask

    initial begin
        logic [DW-1:0] exp1 [10];
        logic [DW-1:0] exp2 [4];
        int            a2 [4];
        int            t, t2, d0, b, l, bad;
        exp1 = '{16'h0001, 16'hAAAA, 16'h5555, 16'hFFFF, 16'hF0F0,
                 16'h0F0F, 16'hCCCC, 16'h3333, 16'h0002, 16'h0004};
        exp2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        a2   = '{126, 127, 0, 1};
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

        reset = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(2);
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rden", ram_rden, 0);
        chk("reset_rdaddr", ram_rdaddr, 0);
        chk("reset_valid", dout_valid, 0);
        chk("reset_dout", dout, 0);

        // Basic run, ready held high
        for (int i = 0; i < 10; i++) mem[i] = exp1[i];
        clr();
        do_start(0, 10, t);
        wait_done(60);
        chk("t1_count", beat_log.size(), 10);
        for (int i = 0; i < 10 && i < beat_log.size(); i++) begin
            chk("t1_data", beat_log[i], exp1[i]);
            chk("t1_beat_cycle", beat_cyc[i], t + 3 + i);
        end
        chk("t1_done_cycle", done_cyc, t + 13);

        // Address wrap
        mem[126] = exp2[0]; mem[127] = exp2[1]; mem[0] = exp2[2]; mem[1] = exp2[3];
        clr();
        do_start(126, 4, t);
        wait_done(40);
        chk("t2_count", beat_log.size(), 4);
        chk("t2_addr_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++) chk("t2_data", beat_log[i], exp2[i]);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_addr", addr_log[i], a2[i]);

        // Backpressure, then a batch of random runs
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        clr();
        rmode = 1;
        do_start(40, 8, t);
        wait_done(400);
        chk("t3_count", beat_log.size(), 8);
        for (int i = 0; i < 8 && i < beat_log.size(); i++) chk("t3_data", beat_log[i], mem[40 + i]);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            clr();
            do_start(b, l, t);
            wait_done(800);
            chk("rand_count", beat_log.size(), l);
        end
        rmode = 0;
        step(2);

        // Full depth, then an empty run
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        clr();
        d0 = done_cnt;
        do_start(0, DEPTH, t);
        wait_done(400);
        chk("t4_addr_count", addr_log.size(), DEPTH);
        bad = 0;
        for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) bad++;
        chk("t4_addr_order", bad, 0);
        chk("t4_done_once", done_cnt - d0, 1);
        clr();
        do_start(5, 0, t);
        step(3);
        chk("t4_len0_done_cycle", done_cyc, t + 1);
        chk("t4_len0_reads", addr_log.size(), 0);
        chk("t4_len0_busy", busy, 0);

        // Abort with the buffer full
        for (int i = 0; i < 10; i++) mem[i] = exp1[i];
        clr();
        do_start(0, 20, t);
        wait_beats(5, 50);
        rmode = 3;
        dout_ready = 1'b0;
        step(4);
        chk("t5_full_valid", dout_valid, 1);
        chk("t5_full_rden", ram_rden, 0);
        d0 = done_cnt;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_valid", dout_valid, 0);
        step(3);
        chk("t5_abort_no_done", done_cnt, d0);
        clr();
        rmode = 0;
        dout_ready = 1'b1;
        do_start(0, 2, t);
        wait_done(40);
        chk("t5_after_count", beat_log.size(), 2);
        if (beat_log.size() >= 2) begin
            chk("t5_after_w0", beat_log[0], 16'h0001);
            chk("t5_after_w1", beat_log[1], 16'hAAAA);
        end

        // Reset in the same situation
        clr();
        do_start(0, 20, t);
        wait_beats(5, 50);
        rmode = 3;
        dout_ready = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_rden", ram_rden, 0);
        chk("t6_rdaddr", ram_rdaddr, 0);
        chk("t6_valid", dout_valid, 0);
        chk("t6_dout", dout, 0);
        rmode = 0;
        dout_ready = 1'b1;
        step(2);

        // Idle abort, start+abort together, and start while busy
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        clr();
        d0 = done_cnt;
        abort = 1'b1;
        do_start(0, 10, t);
        abort = 1'b0;
        step(4);
        do_start(77, 3, t2);
        wait_done(80);
        step(6);
        chk("t7_count", beat_log.size(), 10);
        chk("t7_addr_count", addr_log.size(), 10);
        for (int i = 0; i < 10 && i < addr_log.size(); i++) chk("t7_addr", addr_log[i], i);
        for (int i = 0; i < 10 && i < beat_log.size(); i++) chk("t7_data", beat_log[i], exp1[i]);
        chk("t7_done_once", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/ram_rd_sequencer.md
# ram_rd_sequencer

Read-side controller for the leaf-interface dual-port RAM. On a start command it streams a run of consecutive RAM words (base address, length) out of the read port onto a valid/ready stream. It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, so throughput is one word per cycle and backpressure stalls the stream without losing data. It sits between the RAM's rden/rdaddr/do pins and the leaf's outbound stream logic. The RAM write port is not touched.

## Interface
- DWIDTH, 16, RAM word / stream data width
- AWIDTH, 7, RAM address width; depth = 2^AWIDTH
- clk  in  1  single clock; drives the RAM read port (rdclk) and all logic here
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; accepted only in a cycle where busy=0
- base_addr  in  AWIDTH  first address; sampled when start is accepted
- len  in  AWIDTH+1  number of words, 0..2^AWIDTH; sampled when start is accepted
- abort  in  1  terminate the current run
- busy  out  1  a run is in progress
- done  out  1  one-cycle pulse when a run completes normally
- ram_rden  out  1  to RAM rden
- ram_rdaddr  out  AWIDTH  to RAM rdaddr
- ram_do  in  DWIDTH  from RAM do; valid the cycle after a ram_rden=1 cycle
- dout  out  DWIDTH  stream data
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready; beat transfers when valid&ready

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, start=1:
  - len>0 -> RUN; load addr=base_addr and issue_cnt=len.
  - len=0 -> stay IDLE; done=1 next cycle; no RAM reads.
- start while busy=1 is ignored.
- RUN issue rule: ram_rden=1 when issue_cnt>0 and (fifo_cnt + inflight - pop) < 2.
  - inflight = ram_rden of the previous cycle.
  - pop = dout_valid & dout_ready.
- Each issue presents addr on ram_rdaddr, then addr <= addr+1 and issue_cnt <= issue_cnt-1.
- Address wraps modulo 2^AWIDTH: 127 -> 0 for AWIDTH=7.
- A full-depth run (len=2^AWIDTH) reads every word exactly once.
- ram_do is pushed into the FIFO in the cycle after each issue, unconditionally. The issue rule guarantees space.
- FIFO is 2 entries, first in, first out. dout/dout_valid come from the head register.
- RUN -> DRAIN when the last word is issued. DRAIN -> IDLE when the final beat transfers; done pulses in the following cycle.
- abort=1 while busy:
  - next cycle goes to IDLE with busy=0; FIFO flushed; in-flight read data discarded.
  - no done pulse.
  - abort while idle has no effect.
- If abort and start are asserted in the same idle cycle, start wins.
- reset clears all state from any state, including mid-run and with FIFO full.
- Stream rule: once dout_valid=1, dout and dout_valid hold until the transfer. Exception: abort/reset.

## Timing
- Reset values: busy=0, done=0, ram_rden=0, ram_rdaddr=0, dout_valid=0, dout=0. FIFO empty, state IDLE.
- Start accepted in cycle T:
  - busy=1 and first ram_rden=1 (rdaddr=base_addr) in T+1.
  - ram_do valid in T+2; pushed at the end of T+2; dout_valid=1 in T+3.
- With dout_ready held high: one beat per cycle; len words occupy cycles T+3 .. T+2+len.
- Final beat transfers in cycle F: in F+1, busy=0 and done=1, and a new start is accepted in F+1.
- len=0 start in T: done=1 in T+1; busy stays 0.
- dout_ready=0 with FIFO full: ram_rden=0 until a pop; no word is dropped or duplicated.
- Maximum reads outstanding plus buffered = 2.

## Test plan
- Reset, then start base=0, len=10, ready=1:
  - dout sequence 0x0001, 0xAAAA, 0x5555, 0xFFFF, 0xF0F0, 0x0F0F, 0xCCCC, 0x3333, 0x0002, 0x0004.
  - first valid at T+3, one beat per cycle; done one cycle after the last beat.
- Wrap-around: preload addr 126,127,0,1 = 0x1111, 0x2222, 0x3333, 0x4444; start base=126, len=4.
  - Required: dout is exactly that order; ram_rdaddr goes 126,127,0,1.
- Backpressure: len=8; dout_ready toggles with a random/50% pattern, including 5-cycle low stretches.
  - Required: all 8 words in order, no loss or duplication.
  - Data holds while valid&!ready; ram_rden stays 0 when the FIFO is full.
- Full-depth plus len=0:
  - len=128 reads addresses 0..127 once each; done once.
  - A following start with len=0 gives done at T+1 with zero ram_rden cycles.
- Abort and reset mid-run:
  - len=20; abort after 5 beats with ready low and FIFO full -> next cycle busy=0, dout_valid=0, no done.
  - A following start base=0, len=2 gives 0x0001, 0xAAAA.
  - Repeat with reset in place of abort: all outputs return to their reset values.
- start while busy ignored: a second start mid-run with a different base has no effect on addresses or beat count.
